// File: rtl/video_dac_out.sv
// Video DAC output stage: ordered-dither colour reduction, blanking and sync
// shaping, with RGB, sync and blank kept aligned through two register stages.
module video_dac_out #(
    parameter int IN_BPP  = 8,
    parameter int OUT_BPP = 8,
    parameter int DITHER  = 1
) (
    input  logic               clk_vid,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic [IN_BPP-1:0]  r_in,
    input  logic [IN_BPP-1:0]  g_in,
    input  logic [IN_BPP-1:0]  b_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               de_in,
    input  logic               cfg_dither,
    input  logic               cfg_csync,
    input  logic               cfg_hs_pol,
    input  logic               cfg_vs_pol,
    output logic [OUT_BPP-1:0] vga_r,
    output logic [OUT_BPP-1:0] vga_g,
    output logic [OUT_BPP-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n
);

    localparam int D         = IN_BPP - OUT_BPP;
    localparam int SH_L      = (D >= 2) ? D - 2 : 0;
    localparam int SH_R      = (D >= 2) ? 0 : 2 - D;
    localparam bit DITHER_EN = (DITHER != 0);

    generate
        if (IN_BPP < 1 || IN_BPP > 12 || OUT_BPP < 1 || OUT_BPP > IN_BPP) begin : g_param_check
            $error("video_dac_out: need 1 <= OUT_BPP <= IN_BPP <= 12");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel/line/frame parity, advanced only on pixel-enable samples
    // ------------------------------------------------------------------
    logic r_xp;
    logic r_yp;
    logic r_fp;
    logic r_de_prev;
    logic r_vs_prev;
    logic w_vs_rise;
    logic w_de_fall;

    assign w_vs_rise = vs_in & ~r_vs_prev;
    assign w_de_fall = ~de_in & r_de_prev;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_xp      <= 1'b0;
            r_yp      <= 1'b0;
            r_fp      <= 1'b0;
            r_de_prev <= 1'b0;
            r_vs_prev <= 1'b0;
        end else if (ce_pix) begin
            r_de_prev <= de_in;
            r_vs_prev <= vs_in;
            r_xp      <= de_in ? ~r_xp : 1'b0;
            // A frame start resets the line parity even if a line ends on the same sample
            if (w_vs_rise) begin
                r_yp <= 1'b0;
            end else if (w_de_fall) begin
                r_yp <= ~r_yp;
            end
            if (w_vs_rise) begin
                r_fp <= ~r_fp;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2x2 Bayer threshold, scaled to the D discarded bits
    // ------------------------------------------------------------------
    logic              w_bx;
    logic              w_by;
    logic [1:0]        w_bayer;
    logic [IN_BPP-1:0] w_bayer_ext;
    logic [IN_BPP-1:0] w_t_shaped;
    logic [IN_BPP-1:0] w_t;

    assign w_bx        = r_xp ^ r_fp;
    assign w_by        = r_yp ^ r_fp;
    // {x^y, y} reproduces the matrix 0,2 / 3,1
    assign w_bayer     = {w_bx ^ w_by, w_by};
    assign w_bayer_ext = IN_BPP'(w_bayer);
    // With D = 0 the right shift by 2 leaves nothing, so no dither reaches the data
    assign w_t_shaped  = (D >= 2) ? (w_bayer_ext << SH_L) : (w_bayer_ext >> SH_R);
    assign w_t         = (DITHER_EN && cfg_dither) ? w_t_shaped : '0;

    // ------------------------------------------------------------------
    // Stage 1: sample inputs and threshold
    // ------------------------------------------------------------------
    logic [IN_BPP-1:0] r_s1_t;
    logic              r_s1_hs;
    logic              r_s1_vs;
    logic              r_s1_de;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_s1_t  <= '0;
            r_s1_hs <= 1'b0;
            r_s1_vs <= 1'b0;
            r_s1_de <= 1'b0;
        end else begin
            r_s1_t  <= w_t;
            r_s1_hs <= hs_in;
            r_s1_vs <= vs_in;
            r_s1_de <= de_in;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel quantiser (stage 1 data, stage 2 result)
    // ------------------------------------------------------------------
    logic [IN_BPP-1:0]  w_in_rgb  [3];
    logic [OUT_BPP-1:0] w_out_rgb [3];

    assign w_in_rgb[0] = r_in;
    assign w_in_rgb[1] = g_in;
    assign w_in_rgb[2] = b_in;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [IN_BPP-1:0]  r_s1_pix;
            logic [OUT_BPP-1:0] r_s2_pix;
            logic [IN_BPP:0]    w_sum;
            logic [OUT_BPP-1:0] w_q;

            always_ff @(posedge clk_vid) begin
                if (reset) begin
                    r_s1_pix <= '0;
                end else begin
                    r_s1_pix <= w_in_rgb[gi];
                end
            end

            assign w_sum = {1'b0, r_s1_pix} + {1'b0, r_s1_t};
            // Carry out means the dithered value passed full scale: clamp, never wrap
            assign w_q   = w_sum[IN_BPP] ? '1 : OUT_BPP'(w_sum >> D);

            always_ff @(posedge clk_vid) begin
                if (reset) begin
                    r_s2_pix <= '0;
                end else begin
                    r_s2_pix <= r_s1_de ? w_q : '0;
                end
            end

            assign w_out_rgb[gi] = r_s2_pix;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: sync shaping and blanking
    // ------------------------------------------------------------------
    logic w_cs;
    logic w_hs_next;
    logic w_vs_next;
    logic w_sync_n_next;
    logic r_s2_hs;
    logic r_s2_vs;
    logic r_s2_blank_n;
    logic r_s2_sync_n;

    always_comb begin
        w_cs          = r_s1_hs ^ r_s1_vs;
        w_hs_next     = r_s1_hs ^ ~cfg_hs_pol;
        w_vs_next     = r_s1_vs ^ ~cfg_vs_pol;
        w_sync_n_next = 1'b1;
        if (cfg_csync) begin
            w_hs_next     = w_cs ^ ~cfg_hs_pol;
            w_vs_next     = ~cfg_vs_pol;
            w_sync_n_next = ~w_cs;
        end
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_s2_hs      <= ~cfg_hs_pol;
            r_s2_vs      <= ~cfg_vs_pol;
            r_s2_blank_n <= 1'b0;
            r_s2_sync_n  <= 1'b1;
        end else begin
            r_s2_hs      <= w_hs_next;
            r_s2_vs      <= w_vs_next;
            r_s2_blank_n <= r_s1_de;
            r_s2_sync_n  <= w_sync_n_next;
        end
    end

    assign vga_r       = w_out_rgb[0];
    assign vga_g       = w_out_rgb[1];
    assign vga_b       = w_out_rgb[2];
    assign vga_hs      = r_s2_hs;
    assign vga_vs      = r_s2_vs;
    assign vga_blank_n = r_s2_blank_n;
    assign vga_sync_n  = r_s2_sync_n;

endmodule

// File: tb/tb_video_dac_out.sv
// Scoreboard bench for video_dac_out: three instances (8->8, 8->7, 8->6 bits)
// share stimulus; a counter-based reference model predicts every output sample.
module tb_video_dac_out;

    logic clk_vid = 1'b0;
    always #5 clk_vid = ~clk_vid;

    logic       reset;
    logic       ce_pix;
    logic [7:0] r_in, g_in, b_in;
    logic       hs_in, vs_in, de_in;
    logic       cfg_dither, cfg_csync, cfg_hs_pol, cfg_vs_pol;

    logic [7:0] vr0, vg0, vb0;
    logic [6:0] vr1, vg1, vb1;
    logic [5:0] vr2, vg2, vb2;
    logic [2:0] vhs, vvs, vbn, vsn;

    video_dac_out #(.IN_BPP(8), .OUT_BPP(8), .DITHER(1)) u_dut0 (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .cfg_dither(cfg_dither), .cfg_csync(cfg_csync),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .vga_r(vr0), .vga_g(vg0), .vga_b(vb0),
        .vga_hs(vhs[0]), .vga_vs(vvs[0]), .vga_blank_n(vbn[0]), .vga_sync_n(vsn[0])
    );

    video_dac_out #(.IN_BPP(8), .OUT_BPP(7), .DITHER(1)) u_dut1 (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .cfg_dither(cfg_dither), .cfg_csync(cfg_csync),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
        .vga_hs(vhs[1]), .vga_vs(vvs[1]), .vga_blank_n(vbn[1]), .vga_sync_n(vsn[1])
    );

    video_dac_out #(.IN_BPP(8), .OUT_BPP(6), .DITHER(1)) u_dut2 (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .cfg_dither(cfg_dither), .cfg_csync(cfg_csync),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .vga_r(vr2), .vga_g(vg2), .vga_b(vb2),
        .vga_hs(vhs[2]), .vga_vs(vvs[2]), .vga_blank_n(vbn[2]), .vga_sync_n(vsn[2])
    );

    typedef struct packed {
        logic                 chk;
        logic [2:0][2:0][7:0] rgb;   // [instance][channel]
        logic [2:0]           hs;
        logic [2:0]           vs;
        logic [2:0]           bn;
        logic [2:0]           sn;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state: pixel index in the current active run, lines
    // ended since the last frame start, and frames started since reset.
    int xcnt = 0;
    int ycnt = 0;
    int fcnt = 0;
    bit de_prev = 1'b0;
    bit vs_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        int         bay, t, v;
        bit         x, y, cs;
        logic [7:0] cin [3];
        e       = '0;
        e.chk   = 1'b1;
        cin[0]  = r_in;
        cin[1]  = g_in;
        cin[2]  = b_in;
        x       = ((xcnt % 2) != 0) ^ ((fcnt % 2) != 0);
        y       = ((ycnt % 2) != 0) ^ ((fcnt % 2) != 0);
        bay     = y ? (x ? 1 : 3) : (x ? 2 : 0);
        for (int k = 0; k < 3; k++) begin
            // instance k drops k bits
            t = 0;
            if (cfg_dither && k > 0) t = (k >= 2) ? bay * (1 << (k - 2)) : bay / (1 << (2 - k));
            for (int c = 0; c < 3; c++) begin
                v = int'(cin[c]) + t;
                if (v > 255) v = 255;
                e.rgb[k][c] = de_in ? 8'(v >> k) : 8'd0;
            end
            cs = hs_in ^ vs_in;
            e.bn[k] = de_in;
            if (cfg_csync) begin
                e.hs[k] = cs ? cfg_hs_pol : !cfg_hs_pol;
                e.vs[k] = !cfg_vs_pol;
                e.sn[k] = !cs;
            end else begin
                e.hs[k] = hs_in ? cfg_hs_pol : !cfg_hs_pol;
                e.vs[k] = vs_in ? cfg_vs_pol : !cfg_vs_pol;
                e.sn[k] = 1'b1;
            end
            if (reset) begin
                e.rgb[k] = '0;
                e.bn[k]  = 1'b0;
                e.sn[k]  = 1'b1;
                e.hs[k]  = !cfg_hs_pol;
                e.vs[k]  = !cfg_vs_pol;
            end
        end
        return e;
    endfunction

    task automatic model_update();
        bit vs_rise, de_fall;
        if (reset) begin
            xcnt = 0; ycnt = 0; fcnt = 0; de_prev = 1'b0; vs_prev = 1'b0;
        end else if (ce_pix) begin
            vs_rise = vs_in && !vs_prev;
            de_fall = !de_in && de_prev;
            xcnt    = de_in ? xcnt + 1 : 0;
            if (vs_rise) begin
                ycnt = 0;
                fcnt++;
            end else if (de_fall) begin
                ycnt++;
            end
            de_prev = de_in;
            vs_prev = vs_in;
        end
    endtask

    // One clock edge: predict, let the DUT sample, log the prediction.
    task automatic step();
        exp_t e;
        e = model_out();
        @(posedge clk_vid);
        if (reset) begin
            // samples still in flight are wiped by the reset edge
            foreach (sb_q[i]) sb_q[i] = e;
        end
        sb_q.push_back(e);
        model_update();
        #1;
    endtask

    task automatic set_cfg(input logic dith, input logic csy, input logic hp, input logic vp);
        cfg_dither = dith;
        cfg_csync  = csy;
        cfg_hs_pol = hp;
        cfg_vs_pol = vp;
        // stage-2 config acts on samples already in flight; don't judge those
        foreach (sb_q[i]) sb_q[i].chk = 1'b0;
    endtask

    // Monitor: output after an edge shows the sample taken one edge before it.
    always @(negedge clk_vid) begin : mon
        exp_t e;
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            if (e.chk) begin
                check("rgb_d0", 32'({vr0, vg0, vb0}), 32'({e.rgb[0][0], e.rgb[0][1], e.rgb[0][2]}));
                check("rgb_d1", 32'({vr1, vg1, vb1}),
                      32'({e.rgb[1][0][6:0], e.rgb[1][1][6:0], e.rgb[1][2][6:0]}));
                check("rgb_d2", 32'({vr2, vg2, vb2}),
                      32'({e.rgb[2][0][5:0], e.rgb[2][1][5:0], e.rgb[2][2][5:0]}));
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("ctl_d%0d", k), 32'({vhs[k], vvs[k], vbn[k], vsn[k]}),
                          32'({e.hs[k], e.vs[k], e.bn[k], e.sn[k]}));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit         de_seq [9];
        logic [5:0] pat    [4];
        bit         hsq    [8];
        bit         vsq    [8];
        int         pix;

        de_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        pat    = '{6'd0, 6'd1, 6'd1, 6'd0};
        hsq    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vsq    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; ce_pix = 1'b1;
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
        hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
        cfg_dither = 1'b1; cfg_csync = 1'b0; cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1;

        $display("phase: reset");
        repeat (3) step();
        check("reset_r", 32'(vr0), 32'h0);
        check("reset_blank_n", 32'(vbn[0]), 32'h0);
        check("reset_sync_n", 32'(vsn[0]), 32'h1);
        check("reset_hs", 32'(vhs[0]), 32'(!cfg_hs_pol));

        $display("phase: dither 2x2, frame 0");
        reset = 1'b0;
        r_in = 8'h02; g_in = 8'h02; b_in = 8'h02;
        pix = 0;
        for (int i = 0; i < 9; i++) begin
            de_in = de_seq[i];
            step();
            if (i > 0 && de_seq[i-1]) begin
                check("dither2x2", 32'(vr2), 32'(pat[pix]));
                pix++;
            end
        end

        $display("phase: vsync, dither 2x2, frame 1");
        vs_in = 1'b1; step(); step();
        vs_in = 1'b0; step();
        for (int i = 0; i < 9; i++) begin
            de_in = de_seq[i];
            step();
        end

        $display("phase: passthrough 0xA5");
        de_in = 1'b1; r_in = 8'hA5; g_in = 8'h3C; b_in = 8'h5A;
        step(); step();
        check("pass_a5", 32'(vr0), 32'hA5);
        check("pass_blank_n", 32'(vbn[0]), 32'h1);

        $display("phase: truncation");
        set_cfg(1'b0, 1'b0, 1'b1, 1'b1);
        r_in = 8'h07;
        step(); step();
        check("trunc_07", 32'(vr2), 32'h01);

        $display("phase: saturation");
        set_cfg(1'b1, 1'b0, 1'b1, 1'b1);
        r_in = 8'hFF; g_in = 8'hFE; b_in = 8'hFD;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_d2", 32'(vr2), 32'h3F);
            check("sat_d1", 32'(vr1), 32'h7F);
        end

        $display("phase: composite sync");
        de_in = 1'b0;
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            hs_in = hsq[i];
            vs_in = vsq[i];
            step();
            check("csync_vs_held", 32'(vvs[2]), 32'h1);
            if (i > 0) begin
                check("csync_sync_n", 32'(vsn[2]), 32'(!(hsq[i-1] ^ vsq[i-1])));
                check("csync_hs", 32'(vhs[2]), 32'(!(hsq[i-1] ^ vsq[i-1])));
            end
        end

        $display("phase: reset mid-line");
        hs_in = 1'b0; vs_in = 1'b0;
        set_cfg(1'b1, 1'b0, 1'b1, 1'b1);
        de_in = 1'b1; r_in = 8'h80; g_in = 8'h40; b_in = 8'hC0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_mid_r", 32'(vr0), 32'h0);
        check("rst_mid_blank_n", 32'(vbn[0]), 32'h0);
        check("rst_mid_sync_n", 32'(vsn[0]), 32'h1);
        reset = 1'b0;
        step(); step();
        check("rst_release_r", 32'(vr0), 32'h80);
        check("rst_release_blank_n", 32'(vbn[0]), 32'h1);

        $display("phase: random");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            reset  = ($urandom_range(0, 99) == 0);
            ce_pix = ($urandom_range(0, 3) != 0);
            de_in  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0)  hs_in = ~hs_in;
            if ($urandom_range(0, 39) == 0) vs_in = ~vs_in;
            r_in = 8'($urandom);
            g_in = 8'($urandom);
            b_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r_in = 8'hFF;
            step();
        end

        reset = 1'b0; de_in = 1'b0; ce_pix = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
